seg_scan_mux: RTL and testbench

Time-multiplexed seven-segment display driver. Divides the system clock into a per-digit scan tick and walks a digit index modulo DIGITS. For each digit it drives one active-low anode and the active-low hex segment pattern. It sits directly downstream of the counters and registers that produce hex nibbles, and directly feeds the board's display pins.

---
 rtl/seg_scan_mux.sv | 157 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner: prescaled digit walk, anti-ghost guard, per-frame shadow capture.
// Optional leading-zero suppression is built when LZ_SUPPRESS_EN is defined.
module seg_scan_mux #(
  parameter int DVSR   = 120000,
  parameter int DIGITS = 6,
  parameter int GUARD  = 2
) (
  input  logic                  CLK_12_MHZ,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            sseg,
  output logic                  frame_tick
);

  localparam int MSW = $clog2(DVSR + 1);
  localparam int DW  = $clog2(DIGITS);
  // GUARD < DVSR, so the prescaler width always holds the guard count.
  localparam int GW  = MSW;
  localparam logic [MSW-1:0] MS_LAST    = MSW'(DVSR);
  localparam logic [DW-1:0]  DIG_LAST   = DW'(DIGITS - 1);
  localparam logic [GW-1:0]  GUARD_INIT = GW'(GUARD);

  logic [MSW-1:0]        ms_q, ms_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [GW-1:0]         guard_q, guard_d;
  logic [4*DIGITS-1:0]   hex_q, hex_d;
  logic [DIGITS-1:0]     dp_q, dp_d;
  logic [DIGITS-1:0]     blank_q, blank_d;
  logic                  first_q;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     dig_onehot;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef LZ_SUPPRESS_EN
  logic [DIGITS-1:0] lz_supp;

  // A digit is suppressed while every nibble from the top down to it is zero; digit 0 always shows.
  always_comb begin : lz_calc
    logic run;
    run     = 1'b1;
    lz_supp = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run        = run && (hex_q[4*i +: 4] == 4'h0);
      lz_supp[i] = run;
    end
  end
`endif

  always_comb begin
    tick       = (ms_q == MS_LAST);
    wrap       = tick && (dig_q == DIG_LAST);
    ms_d       = tick ? '0 : ms_q + 1'b1;

    dig_d = dig_q;
    if (tick) dig_d = wrap ? '0 : dig_q + 1'b1;

    guard_d = guard_q;
    if (tick)              guard_d = GUARD_INIT;
    else if (guard_q != '0) guard_d = guard_q - 1'b1;

    // Shadow only moves at frame boundaries so a frame is never torn.
    hex_d   = hex_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (first_q || wrap) begin
      hex_d   = hex_in;
      dp_d    = dp_in;
      blank_d = blank_in;
    end

    nib        = hex_q[{dig_q, 2'b00} +: 4];
    dig_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << dig_q;

    an_d   = '1;
    sseg_d = 8'hFF;
    if (guard_q == '0 && !blank_q[dig_q]) begin
`ifdef LZ_SUPPRESS_EN
      if (lz_supp[dig_q]) begin
        if (dp_q[dig_q]) begin
          an_d   = ~dig_onehot;
          sseg_d = 8'h7F;
        end
      end else begin
        an_d   = ~dig_onehot;
        sseg_d = {~dp_q[dig_q], hex7(nib)};
      end
`else
      an_d   = ~dig_onehot;
      sseg_d = {~dp_q[dig_q], hex7(nib)};
`endif
    end

    frame_d = wrap;
  end

  always_ff @(posedge CLK_12_MHZ) begin
    if (RST) begin
      ms_q    <= '0;
      dig_q   <= '0;
      guard_q <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      first_q <= 1'b1;
      an_q    <= '1;
      sseg_q  <= 8'hFF;
      frame_q <= 1'b0;
    end else begin
      ms_q    <= ms_d;
      dig_q   <= dig_d;
      guard_q <= guard_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      first_q <= 1'b0;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      frame_q <= frame_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DVSR=3, DIGITS=6, GUARD=1: per-frame vector table plus reset corners.
// Frame expectations switch when LZ_SUPPRESS_EN is defined.
module tb_seg_scan_mux;

  localparam int DVSR   = 3;
  localparam int DIGITS = 6;
  localparam int GUARD  = 1;

  logic        clk;
  logic        rst;
  logic [23:0] hex_in;
  logic [5:0]  dp_in;
  logic [5:0]  blank_in;
  logic [5:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int total;
  int bad;

  typedef struct {
    logic [23:0] hex;
    logic [5:0]  dp;
    logic [5:0]  blank;
    logic [35:0] exp_an;    // {d5..d0}, 6 bits each
    logic [47:0] exp_sseg;  // {d5..d0}, 8 bits each
  } frame_vec_t;

  frame_vec_t vecs[6];

  seg_scan_mux #(.DVSR(DVSR), .DIGITS(DIGITS), .GUARD(GUARD)) dut (
    .CLK_12_MHZ (clk),
    .RST        (rst),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic apply(input int vi);
    hex_in   = vecs[vi].hex;
    dp_in    = vecs[vi].dp;
    blank_in = vecs[vi].blank;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_an"},   {2'b00, an}, 8'h3F);
    check({tag, "_sseg"}, sseg,        8'hFF);
    check({tag, "_ft"},   {7'd0, frame_tick}, 8'h00);
  endtask

  // One digit slot: optional guard clock, then nvis visible clocks.
  // Inputs for the next frame are driven while digit 2 is on screen.
  task automatic run_digit(input int vi, input int ph, input int d, input bit with_guard,
                           input int nvis, input int nxt);
    logic [5:0] e_an;
    logic [7:0] e_ss;
    logic       e_ft;
    e_an = vecs[vi].exp_an[6*d +: 6];
    e_ss = vecs[vi].exp_sseg[8*d +: 8];
    if (with_guard) begin
      step();
      check($sformatf("p%0d_d%0d_guard_an", ph, d),   {2'b00, an}, 8'h3F);
      check($sformatf("p%0d_d%0d_guard_sseg", ph, d), sseg, 8'hFF);
      check($sformatf("p%0d_d%0d_guard_ft", ph, d),   {7'd0, frame_tick}, 8'h00);
    end
    for (int c = 0; c < nvis; c++) begin
      step();
      e_ft = (d == DIGITS - 1) && (c == 2);
      check($sformatf("p%0d_d%0d_c%0d_an", ph, d, c),   {2'b00, an}, {2'b00, e_an});
      check($sformatf("p%0d_d%0d_c%0d_sseg", ph, d, c), sseg, e_ss);
      check($sformatf("p%0d_d%0d_c%0d_ft", ph, d, c),   {7'd0, frame_tick}, {7'd0, e_ft});
      if (d == 2 && c == 0 && nxt >= 0) apply(nxt);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{hex: 24'h012345, dp: 6'b000000, blank: 6'b000000,
                exp_an:   {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                exp_sseg: {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
    vecs[1] = vecs[0];
    vecs[2] = '{hex: 24'hABCDEF, dp: 6'b000000, blank: 6'b000000,
                exp_an:   {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                exp_sseg: {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E}};
    vecs[3] = '{hex: 24'hABCDEF, dp: 6'b000011, blank: 6'b000010,
                exp_an:   {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3F, 6'h3E},
                exp_sseg: {8'h88, 8'h83, 8'hC6, 8'hA1, 8'hFF, 8'h0E}};
    vecs[4] = '{hex: 24'h012345, dp: 6'b101000, blank: 6'b000000,
                exp_an:   {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                exp_sseg: {8'h40, 8'hF9, 8'h24, 8'hB0, 8'h99, 8'h92}};
`ifdef LZ_SUPPRESS_EN
    vecs[5] = '{hex: 24'h000120, dp: 6'b001000, blank: 6'b000000,
                exp_an:   {6'h3F, 6'h3F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                exp_sseg: {8'hFF, 8'hFF, 8'h7F, 8'hF9, 8'hA4, 8'hC0}};
`else
    vecs[5] = '{hex: 24'h000120, dp: 6'b001000, blank: 6'b000000,
                exp_an:   {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E},
                exp_sseg: {8'hC0, 8'hC0, 8'h40, 8'hF9, 8'hA4, 8'hC0}};
`endif

    // Power-on reset held for three clocks.
    rst      = 1'b1;
    hex_in   = '0;
    dp_in    = '0;
    blank_in = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset($sformatf("rst%0d", i));
    end
    rst = 1'b0;
    apply(0);
    step();  // shadow capture edge

    // Six frames; each frame's inputs were driven mid-way through the previous one.
    for (int f = 0; f < 6; f++) begin
      for (int d = 0; d < DIGITS; d++) begin
        run_digit(f, f, d, !(f == 0 && d == 0), 3, (f < 5) ? f + 1 : 5);
      end
    end

    // Reset asserted while digit 3 is on screen.
    for (int d = 0; d < 3; d++) run_digit(5, 6, d, 1'b1, 3, -1);
    run_digit(5, 6, 3, 1'b1, 1, -1);
    rst = 1'b1;
    step();
    check_reset("midrst0");
    step();
    check_reset("midrst1");
    rst = 1'b0;
    step();  // shadow capture edge
    run_digit(5, 7, 0, 1'b0, 3, -1);
    run_digit(5, 7, 1, 1'b1, 3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
